sobel_window_buffer: RTL and testbench

Producer side of the 3x3 window interface consumed by `horizontal_gradient` and its vertical counterpart. It accepts a raster-order 8-bit grayscale pixel stream and keeps the two previous image lines in line buffers. For every pixel that completes a full 3x3 neighbourhood, it emits that neighbourhood as `windowBuffer[0:8]` together with a one-cycle `start_calculations` strobe.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_line_buffer.sv | 27 ++
 rtl/sobel_window_buffer.sv | 165 ++++++++++++++++
 tb/tb_sobel_window_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window producer and the gradient blocks.
// Window indices are row-major: TL (oldest line, oldest column) through BR (newest pixel).
package sobel_pkg;

  localparam int PIXEL_W     = 8;
  localparam int WINDOW_SIZE = 9;

  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam int TL = 0;
  localparam int TC = 1;
  localparam int TR = 2;
  localparam int ML = 3;
  localparam int MC = 4;
  localparam int MR = 5;
  localparam int BL = 6;
  localparam int BC = 7;
  localparam int BR = 8;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// One image line of pixel storage, addressed by column.
// The read port shows the old entry in the same cycle that i_en overwrites it.
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter  int DEPTH  = 640,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               i_en,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [PIXEL_W-1:0] i_wdata,
  output logic [PIXEL_W-1:0] o_rdata
);

  pixel_t r_mem [0:DEPTH-1];

  assign o_rdata = r_mem[i_addr];

  // No reset: stale contents are only ever read during the FILL rows.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/sobel_window_buffer.sv
// Raster pixel stream in, 3x3 neighbourhood plus one-cycle strobe out.
// Define SOBEL_WB_WINDOW_CNT_EN to add the saturating window_count output.
module sobel_window_buffer
  import sobel_pkg::*;
#(
  parameter  int IMG_WIDTH  = 640,
  parameter  int IMG_HEIGHT = 480,
  localparam int COL_W      = $clog2(IMG_WIDTH),
  localparam int ROW_W      = $clog2(IMG_HEIGHT)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [PIXEL_W-1:0] pixel_in,
  input  logic               pixel_valid,
  input  logic               frame_start,
  output logic [PIXEL_W-1:0] windowBuffer [0:WINDOW_SIZE-1],
  output logic               start_calculations,
  output logic [ROW_W-1:0]   center_row,
  output logic [COL_W-1:0]   center_col,
  output logic               frame_done,
`ifdef SOBEL_WB_WINDOW_CNT_EN
  output logic [19:0]        window_count,
`endif
  output logic               dbg_state
);

  // Handshake: the block is always ready, so every rising edge with
  // pixel_valid high consumes pixel_in; there is no back-pressure.

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_addr;
  logic             w_frame_wrap;
  logic             w_strobe;
  pixel_t           w_line0_rd;
  pixel_t           w_line1_rd;
  pixel_t           r_win [0:WINDOW_SIZE-1];
  logic             r_strobe;
  logic             r_frame_done;
  logic [ROW_W-1:0] r_center_row;
  logic [COL_W-1:0] r_center_col;

  // frame_start makes the current pixel land at (0,0) regardless of the counters.
  assign w_addr       = frame_start ? '0 : r_col;
  assign w_frame_wrap = pixel_valid && !frame_start &&
                        (r_row == LAST_ROW) && (r_col == LAST_COL);
  assign w_strobe     = pixel_valid && !frame_start &&
                        (r_state == STREAM) && (r_col >= COL_W'(2));

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line0 (
    .clk     (clk),
    .i_en    (pixel_valid),
    .i_addr  (w_addr),
    .i_wdata (pixel_in),
    .o_rdata (w_line0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_WIDTH)) u_line1 (
    .clk     (clk),
    .i_en    (pixel_valid),
    .i_addr  (w_addr),
    .i_wdata (w_line0_rd),
    .o_rdata (w_line1_rd)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = FILL;
    end else if (pixel_valid) begin
      case (r_state)
        FILL:    if (r_row == ROW_W'(1) && r_col == LAST_COL) w_state_nxt = STREAM;
        STREAM:  if (w_frame_wrap) w_state_nxt = FILL;
        default: w_state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (frame_start) begin
      r_row <= '0;
      r_col <= pixel_valid ? COL_W'(1) : '0;
    end else if (pixel_valid) begin
      if (r_col == LAST_COL) begin
        r_col <= '0;
        r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Shift left one column; the new right column is {line1, line0, pixel_in}.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < WINDOW_SIZE; i++) begin
        r_win[i] <= '0;
      end
    end else if (pixel_valid) begin
      r_win[TL] <= r_win[TC];
      r_win[TC] <= r_win[TR];
      r_win[TR] <= w_line1_rd;
      r_win[ML] <= r_win[MC];
      r_win[MC] <= r_win[MR];
      r_win[MR] <= w_line0_rd;
      r_win[BL] <= r_win[BC];
      r_win[BC] <= r_win[BR];
      r_win[BR] <= pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
      r_center_row <= '0;
      r_center_col <= '0;
    end else begin
      r_strobe     <= w_strobe;
      r_frame_done <= w_frame_wrap;
      if (w_strobe) begin
        r_center_row <= r_row - ROW_W'(1);
        r_center_col <= r_col - COL_W'(1);
      end
    end
  end

`ifdef SOBEL_WB_WINDOW_CNT_EN
  logic [19:0] r_win_cnt;

  always_ff @(posedge clk) begin
    if (!n_rst || frame_start) begin
      r_win_cnt <= '0;
    end else if (w_strobe && (r_win_cnt != '1)) begin
      r_win_cnt <= r_win_cnt + 20'd1;
    end
  end

  assign window_count = r_win_cnt;
`endif

  assign windowBuffer       = r_win;
  assign start_calculations = r_strobe;
  assign center_row         = r_center_row;
  assign center_col         = r_center_col;
  assign frame_done         = r_frame_done;
  assign dbg_state          = r_state;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Self-checking bench for sobel_window_buffer on a 5x4 image.
// Reference model: a 2-D image array indexed by raster position; windows are sliced from it.
module tb_sobel_window_buffer;

  localparam int W = 5;
  localparam int H = 4;

  logic       clk;
  logic       n_rst;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] windowBuffer [0:8];
  logic       start_calculations;
  logic [1:0] center_row;
  logic [2:0] center_col;
  logic       frame_done;
  logic       dbg_state;
`ifdef SOBEL_WB_WINDOW_CNT_EN
  logic [19:0] window_count;
`endif

  sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk                (clk),
    .n_rst              (n_rst),
    .pixel_in           (pixel_in),
    .pixel_valid        (pixel_valid),
    .frame_start        (frame_start),
    .windowBuffer       (windowBuffer),
    .start_calculations (start_calculations),
    .center_row         (center_row),
    .center_col         (center_col),
    .frame_done         (frame_done),
`ifdef SOBEL_WB_WINDOW_CNT_EN
    .window_count       (window_count),
`endif
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- model / scoreboard state ----------------
  // Vector layout: {centre row (2), centre col (3), window[0..8] (72)}.
  logic [7:0]  img [0:H-1][0:W-1];
  logic [76:0] exp_q[$];
  logic [76:0] last_exp;
  logic [76:0] got;
  logic [76:0] want;
  logic [76:0] first_vec;
  logic [76:0] done_vec;
  logic [76:0] ref_first;
  logic [76:0] ref_done;
  logic        exp_strobe;
  logic        exp_done;
  logic        win_fresh;
  int          m_r;
  int          m_c;
  int          n_str;
  int          n_vec;
  int          n_err;

  function automatic logic [76:0] model_vec(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], img[r-2+i][c-2+j]};
    return {2'(r - 1), 3'(c - 1), w};
  endfunction

  function automatic logic [76:0] dut_vec();
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w = {w[63:0], windowBuffer[i]};
    return {center_row, center_col, w};
  endfunction

  function automatic logic [7:0] pattern_pix(input int r, input int c, input int base);
    if (base < 0) return 8'($urandom_range(0, 255));
    return 8'(base + 16 * r + c);
  endfunction

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic fs, input logic [7:0] p);
    @(negedge clk);
    pixel_valid = v;
    frame_start = fs;
    pixel_in    = p;
    exp_strobe  = 1'b0;
    exp_done    = 1'b0;
    if (fs) begin
      m_r = 0;
      m_c = 0;
    end
    if (v) begin
      img[m_r][m_c] = p;
      if (!fs && m_r >= 2 && m_c >= 2) begin
        exp_strobe = 1'b1;
        last_exp   = model_vec(m_r, m_c);
        exp_q.push_back(last_exp);
      end
      exp_done  = !fs && (m_r == H - 1) && (m_c == W - 1);
      win_fresh = exp_strobe;
      if (m_c == W - 1) begin
        m_c = 0;
        m_r = (m_r == H - 1) ? 0 : m_r + 1;
      end else begin
        m_c++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_r = 0;
    m_c = 0;
    exp_q.delete();
    last_exp  = '0;
    win_fresh = 1'b1;
  endtask

  // One frame with pixel_valid high with probability pct; compares every cycle.
  task automatic run_frame(input int pct, input int base, input string tag);
    int k;
    k     = 0;
    n_str = 0;
    while (k < W * H) begin
      if ($urandom_range(0, 99) < pct) begin
        step(1'b1, 1'b0, pattern_pix(k / W, k % W, base));
        k++;
      end else begin
        step(1'b0, 1'b0, 8'($urandom_range(0, 255)));
      end
      n_vec++;
      if (start_calculations !== exp_strobe || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL %s strobe/done before (%0d,%0d): got %b/%b want %b/%b",
                 tag, m_r, m_c, start_calculations, frame_done, exp_strobe, exp_done);
      end
      if (start_calculations === 1'b1 && exp_q.size() != 0) begin
        got  = dut_vec();
        want = exp_q.pop_front();
        if (n_str == 0) first_vec = got;
        if (frame_done === 1'b1) done_vec = got;
        n_str++;
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL %s window: got %h want %h", tag, got, want);
        end
      end else if (win_fresh) begin
        got = dut_vec();
        n_vec++;
        if (got !== last_exp) begin
          n_err++;
          $display("FAIL %s hold: got %h want %h", tag, got, last_exp);
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_rst       = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in    = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (dut_vec() !== 77'd0 || start_calculations !== 1'b0 || frame_done !== 1'b0 ||
        dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset outputs: got vec=%h strobe=%b done=%b state=%b want all zero",
               dut_vec(), start_calculations, frame_done, dbg_state);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_full_frame();
    int gx;
    run_frame(100, 0, "full_frame");
    ref_first = first_vec;
    ref_done  = done_vec;
    n_vec++;
    if (n_str !== 6) begin
      n_err++;
      $display("FAIL full_frame strobe count: got %0d want 6", n_str);
    end
    n_vec++;
    if (first_vec !== {2'd1, 3'd1, 8'd0, 8'd1, 8'd2, 8'd16, 8'd17, 8'd18, 8'd32, 8'd33, 8'd34}) begin
      n_err++;
      $display("FAIL full_frame first window: got %h want centre (1,1) window 0,1,2,16,17,18,32,33,34",
               first_vec);
    end
    // Horizontal gradient: (TR + 2*MR + BR) - (TL + 2*ML + BL).
    gx = (int'(first_vec[55:48]) + 2 * int'(first_vec[31:24]) + int'(first_vec[7:0])) -
         (int'(first_vec[71:64]) + 2 * int'(first_vec[47:40]) + int'(first_vec[23:16]));
    n_vec++;
    if (gx != 8) begin
      n_err++;
      $display("FAIL full_frame gx: got %0d want 8", gx);
    end
    n_vec++;
    if (done_vec[76:72] !== {2'd2, 3'd3} || done_vec[7:0] !== 8'd52 || done_vec[71:64] !== 8'd18) begin
      n_err++;
      $display("FAIL full_frame done window: got %h want centre (2,3) TL=18 BR=52", done_vec);
    end
  endtask

  task automatic test_valid_gaps();
    run_frame(50, 0, "valid_gaps");
    n_vec++;
    if (n_str !== 6 || first_vec !== ref_first || done_vec !== ref_done) begin
      n_err++;
      $display("FAIL valid_gaps vs full frame: got n=%0d first=%h done=%h want n=6 first=%h done=%h",
               n_str, first_vec, done_vec, ref_first, ref_done);
    end
  endtask

  task automatic test_two_frames();
    for (int f = 0; f < 2; f++) begin
      run_frame(100, 0, "two_frames");
      n_vec++;
      if (n_str !== 6 || first_vec !== ref_first || done_vec !== ref_done) begin
        n_err++;
        $display("FAIL two_frames frame %0d: got n=%0d first=%h done=%h want n=6 first=%h done=%h",
                 f, n_str, first_vec, done_vec, ref_first, ref_done);
      end
    end
  endtask

  task automatic test_frame_start();
    int       nk;
    int       n_new;
    logic     seen;
    logic [7:0] p;
    n_new = 0;
    seen  = 1'b0;
    for (int k = 0; k < 13 + W * H; k++) begin
      if (k < 13) begin
        p = pattern_pix(k / W, k % W, 0);
      end else begin
        nk = k - 13;
        p  = pattern_pix(nk / W, nk % W, 100);
      end
      step(1'b1, (k == 13), p);
      n_vec++;
      if (start_calculations !== exp_strobe || frame_done !== exp_done) begin
        n_err++;
        $display("FAIL frame_start strobe/done k=%0d: got %b/%b want %b/%b",
                 k, start_calculations, frame_done, exp_strobe, exp_done);
      end
      if (start_calculations === 1'b1 && exp_q.size() != 0) begin
        got  = dut_vec();
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL frame_start window k=%0d: got %h want %h", k, got, want);
        end
        if (k > 13) begin
          n_new++;
          if (!seen) begin
            seen = 1'b1;
            n_vec++;
            if (got[76:72] !== {2'd1, 3'd1} || got[71:64] !== 8'd100 || k !== 13 + 2 * W + 2) begin
              n_err++;
              $display("FAIL frame_start first new window k=%0d: got %h want centre (1,1) TL=100 at k=%0d",
                       k, got, 13 + 2 * W + 2);
            end
          end
        end
      end
    end
    n_vec++;
    if (n_new !== 6) begin
      n_err++;
      $display("FAIL frame_start new-frame strobes: got %0d want 6", n_new);
    end
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 18; k++) step(1'b1, 1'b0, pattern_pix(k / W, k % W, 0));
    @(negedge clk);
    n_rst       = 1'b0;
    pixel_valid = 1'b1;
    pixel_in    = 8'hAA;
    @(posedge clk);
    #1;
    model_reset();
    n_vec++;
    if (dut_vec() !== 77'd0 || start_calculations !== 1'b0 || frame_done !== 1'b0 ||
        dbg_state !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid outputs: got vec=%h strobe=%b done=%b state=%b want all zero",
               dut_vec(), start_calculations, frame_done, dbg_state);
    end
    @(negedge clk);
    n_rst       = 1'b1;
    pixel_valid = 1'b0;
    run_frame(70, -1, "reset_mid");
    n_vec++;
    if (first_vec[76:72] !== {2'd1, 3'd1} || n_str !== 6) begin
      n_err++;
      $display("FAIL reset_mid first centre: got (%0d,%0d) n=%0d want (1,1) n=6",
               first_vec[76:75], first_vec[74:72], n_str);
    end
  endtask

`ifdef SOBEL_WB_WINDOW_CNT_EN
  task automatic test_window_count();
    run_frame(100, -1, "window_count");
    n_vec++;
    if (window_count !== 20'd6) begin
      n_err++;
      $display("FAIL window_count at frame_done: got %0d want 6", window_count);
    end
    step(1'b0, 1'b1, 8'h00);
    n_vec++;
    if (window_count !== 20'd0) begin
      n_err++;
      $display("FAIL window_count after frame_start: got %0d want 0", window_count);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    first_vec = '0;
    done_vec  = '0;
    test_reset();
    test_full_frame();
    test_valid_gaps();
    test_two_frames();
    test_frame_start();
    test_reset_mid_stream();
`ifdef SOBEL_WB_WINDOW_CNT_EN
    test_window_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
